mem_burst_ctrl: RTL and testbench

- Burst sequencer sitting directly upstream of the 256x8 data memory; it is the only master of the memory's mem_read/mem_write/address/write_data pins.
- On a start command it moves len consecutive bytes between data memory and a byte stream. Read direction streams memory to the crypto core; write direction streams the core into memory.
- Used for key/block load and ciphertext store, with a valid/ready stream on each side.

---
 rtl/mem_burst_pkg.sv | 13 +
 rtl/mem_burst_ctrl_if.sv | 38 +++
 rtl/mem_burst_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_burst_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared constants for the burst sequencer: FSM encodings, direction codes, burst cap.
package mem_burst_pkg;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_FETCH = 3'd1;
    localparam logic [2:0] RD_HOLD  = 3'd2;
    localparam logic [2:0] WR_XFER  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int MAX_BURST = 16;
endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Command, stream and data-memory bus of the burst sequencer.
// master = sequencer side, slave = environment (command source, core, memory).
interface mem_burst_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
);
    logic              start;
    logic              dir;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        input  start, dir, base_addr, len, m_ready, s_valid, s_data, mem_read_data,
        output busy, done, err, m_valid, m_data, s_ready,
               mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        output start, dir, base_addr, len, m_ready, s_valid, s_data, mem_read_data,
        input  busy, done, err, m_valid, m_data, s_ready,
               mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer between the 256x8 data memory and the crypto-core byte streams.
// Optional out-of-range rejection with MEM_BURST_BOUNDS_EN; default build wraps addresses.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic          clk,
    input  logic          rst,
    mem_burst_ctrl_if.master bus
);
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  len_eff;

    assign len_eff = (bus.len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : bus.len;

`ifdef MEM_BURST_BOUNDS_EN
    logic              err_q, err_d;
    logic [ADDR_W:0]   end_addr;
    logic              oob;
    assign end_addr = {1'b0, bus.base_addr} + (ADDR_W+1)'(len_eff);
    assign oob      = end_addr > {1'b1, {ADDR_W{1'b0}}};
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        done_d    = 1'b0;
`ifdef MEM_BURST_BOUNDS_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_eff == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
`ifdef MEM_BURST_BOUNDS_EN
                    else if (oob) begin
                        err_d = 1'b1;
                    end
`endif
                    else begin
                        addr_d  = bus.base_addr;
                        count_d = len_eff;
                        state_d = (bus.dir == DIR_READ) ? RD_FETCH : WR_XFER;
                    end
                end
            end
            RD_FETCH: begin
                m_data_d  = bus.mem_read_data;
                m_valid_d = 1'b1;
                state_d   = RD_HOLD;
            end
            RD_HOLD: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    addr_d    = addr_q + 1'b1;
                    count_d   = count_q - 1'b1;
                    if (count_q == LEN_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_FETCH;
                    end
                end
            end
            WR_XFER: begin
                if (bus.s_valid) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == LEN_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RD_FETCH) || (state_d == RD_HOLD) || (state_d == WR_XFER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEM_BURST_BOUNDS_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MEM_BURST_BOUNDS_EN
            err_q     <= err_d;
`endif
        end
    end

    // Strobes are gated by rst so a reset cycle can never commit a memory write.
    assign bus.mem_read       = !rst && (state_q == RD_FETCH);
    assign bus.mem_write      = !rst && (state_q == WR_XFER) && bus.s_valid;
    assign bus.s_ready        = !rst && (state_q == WR_XFER);
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = bus.s_data;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_data         = m_data_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a combinational-read 256x8 memory model.
module tb_mem_burst_ctrl;
    logic clk;
    logic rst;
    logic [7:0] mem [256];
    int vecs = 0;
    int errs = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic [7:0] got_d[$];
    int got_c[$];
    int rd0, wr0, dn0;

    mem_burst_ctrl_if bus ();
    mem_burst_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_read_data = mem[bus.mem_address];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
        if (bus.mem_write) wr_cnt <= wr_cnt + 1;
        if (bus.mem_read) rd_cnt <= rd_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input int n);
        got_d.delete();
        got_c.delete();
        for (int i = 0; i < 60 && got_d.size() < n; i++) begin
            step();
            if (bus.m_valid && bus.m_ready) begin
                got_d.push_back(bus.m_data);
                got_c.push_back(cyc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1; mem[8'h12] = 8'hA2; mem[8'h13] = 8'hA3;
        mem[8'h20] = 8'h5A; mem[8'h21] = 8'h5B;
        mem[8'h60] = 8'hE0; mem[8'h61] = 8'hE1; mem[8'h62] = 8'hE2; mem[8'h63] = 8'hE3;
        rst = 1'b1;
        bus.start = 0; bus.dir = 0; bus.base_addr = 0; bus.len = 0;
        bus.m_ready = 0; bus.s_valid = 1; bus.s_data = 8'h99;
        step(); step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mvalid", bus.m_valid, 0);
        chk("rst_mdata", bus.m_data, 0);
        chk("rst_memwr", bus.mem_write, 0);
        chk("rst_memrd", bus.mem_read, 0);
        chk("rst_sready", bus.s_ready, 0);
        rst = 1'b0; bus.s_valid = 0;
        step();

        // Read burst 0x10..0x13, m_ready high.
        rd0 = rd_cnt; dn0 = done_cnt;
        bus.start = 1; bus.dir = 0; bus.base_addr = 8'h10; bus.len = 4; bus.m_ready = 1;
        step();
        bus.start = 0;
        chk("rd_busy", bus.busy, 1);
        chk("rd_fetch_rd", bus.mem_read, 1);
        chk("rd_fetch_addr", bus.mem_address, 8'h10);
        collect(4);
        chk("rd_nbytes", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) chk("rd_byte", got_d[i], 8'hA0 + i);
        for (int i = 1; i < got_c.size(); i++) chk("rd_spacing", got_c[i] - got_c[i-1], 2);
        step();
        chk("rd_done", bus.done, 1);
        chk("rd_done_busy", bus.busy, 0);
        step();
        chk("rd_done_gone", bus.done, 0);
        chk("rd_busy_after", bus.busy, 0);
        chk("rd_done_cnt", done_cnt - dn0, 1);
        chk("rd_reads", rd_cnt - rd0, 4);

        // Read stall: m_ready low for 5 cycles.
        bus.start = 1; bus.base_addr = 8'h20; bus.len = 2; bus.m_ready = 0;
        step();
        bus.start = 0;
        step();
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, 8'h5A);
            chk("stall_rd", bus.mem_read, 0);
            chk("stall_addr", bus.mem_address, 8'h20);
            step();
        end
        chk("stall_reads", rd_cnt - rd0, 0);
        bus.m_ready = 1;
        step();
        collect(1);
        chk("stall_nbytes", got_d.size(), 1);
        if (got_d.size() > 0) chk("stall_byte2", got_d[0], 8'h5B);
        step();
        chk("stall_done", bus.done, 1);
        step();

        // Write burst with s_valid toggling.
        wr0 = wr_cnt;
        bus.start = 1; bus.dir = 1; bus.base_addr = 8'h40; bus.len = 3;
        step();
        bus.start = 0;
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = (i % 2 == 0);
            bus.s_data = (i % 2 == 0) ? 8'(8'h11 * (i / 2 + 1)) : 8'h00;
            #1;
            chk("wr_sready", bus.s_ready, 1);
            chk("wr_memwr", bus.mem_write, (i % 2 == 0));
            step();
        end
        bus.s_valid = 0;
        chk("wr_done", bus.done, 1);
        chk("wr_done_busy", bus.busy, 0);
        chk("wr_done_sready", bus.s_ready, 0);
        step();
        chk("wr_count", wr_cnt - wr0, 3);
        chk("wr_m40", mem[8'h40], 8'h11);
        chk("wr_m41", mem[8'h41], 8'h22);
        chk("wr_m42", mem[8'h42], 8'h33);
        chk("wr_m43", mem[8'h43], 8'h00);

        // Address wrap 0xFE..0x00 (rejected when bounds checking is built in).
        wr0 = wr_cnt; dn0 = done_cnt;
        bus.start = 1; bus.dir = 1; bus.base_addr = 8'hFE; bus.len = 3;
        bus.s_valid = 1; bus.s_data = 8'h71;
        step();
        bus.start = 0;
`ifdef MEM_BURST_BOUNDS_EN
        #1;
        chk("oob_err", bus.err, 1);
        chk("oob_busy", bus.busy, 0);
        chk("oob_sready", bus.s_ready, 0);
        step();
        chk("oob_err_gone", bus.err, 0);
        bus.s_valid = 0;
        step();
        chk("oob_writes", wr_cnt - wr0, 0);
        chk("oob_done", done_cnt - dn0, 0);
        chk("oob_mFE", mem[8'hFE], 8'h00);
`else
        for (int i = 0; i < 3; i++) begin
            bus.s_data = 8'(8'h71 + i);
            #1;
            chk("wrap_addr", bus.mem_address, 8'(8'hFE + i));
            step();
        end
        bus.s_valid = 0;
        chk("wrap_done", bus.done, 1);
        chk("wrap_err", bus.err, 0);
        step();
        chk("wrap_mFE", mem[8'hFE], 8'h71);
        chk("wrap_mFF", mem[8'hFF], 8'h72);
        chk("wrap_m00", mem[8'h00], 8'h73);
`endif

        // len=0 completes next cycle with no access.
        rd0 = rd_cnt; wr0 = wr_cnt;
        bus.start = 1; bus.dir = 0; bus.base_addr = 8'h10; bus.len = 0;
        step();
        bus.start = 0;
        chk("len0_done", bus.done, 1);
        chk("len0_busy", bus.busy, 0);
        step();
        chk("len0_done_gone", bus.done, 0);
        chk("len0_access", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // Second start during a burst is ignored.
        wr0 = wr_cnt; dn0 = done_cnt;
        bus.start = 1; bus.dir = 0; bus.base_addr = 8'h10; bus.len = 2; bus.m_ready = 1;
        step();
        bus.dir = 1; bus.base_addr = 8'h80; bus.len = 5; bus.s_valid = 1; bus.s_data = 8'hEE;
        collect(2);
        bus.start = 0; bus.s_valid = 0;
        chk("bs_nbytes", got_d.size(), 2);
        if (got_d.size() == 2) begin
            chk("bs_b0", got_d[0], 8'hA0);
            chk("bs_b1", got_d[1], 8'hA1);
        end
        step();
        chk("bs_done", bus.done, 1);
        step();
        chk("bs_writes", wr_cnt - wr0, 0);
        chk("bs_done_cnt", done_cnt - dn0, 1);

        // len=31 is clamped to 16 bytes.
        wr0 = wr_cnt;
        bus.start = 1; bus.dir = 1; bus.base_addr = 8'h90; bus.len = 5'd31;
        bus.s_valid = 1; bus.s_data = 8'hCC;
        step();
        bus.start = 0;
        for (int i = 0; i < 40 && !bus.done; i++) step();
        bus.s_valid = 0;
        chk("clamp_done", bus.done, 1);
        step();
        chk("clamp_writes", wr_cnt - wr0, 16);
        chk("clamp_m9F", mem[8'h9F], 8'hCC);
        chk("clamp_mA0", mem[8'hA0], 8'h00);

        // Reset after 2 of 4 write bytes.
        wr0 = wr_cnt; dn0 = done_cnt;
        bus.start = 1; bus.dir = 1; bus.base_addr = 8'h60; bus.len = 4;
        step();
        bus.start = 0;
        bus.s_valid = 1; bus.s_data = 8'h01;
        step();
        bus.s_data = 8'h02;
        step();
        rst = 1; bus.s_data = 8'h03;
        #1;
        chk("rstw_memwr", bus.mem_write, 0);
        chk("rstw_sready", bus.s_ready, 0);
        step();
        chk("rstw_busy", bus.busy, 0);
        chk("rstw_mvalid", bus.m_valid, 0);
        chk("rstw_mdata", bus.m_data, 0);
        chk("rstw_done", bus.done, 0);
        rst = 0; bus.s_valid = 0;
        step();
        step();
        chk("rstw_done_cnt", done_cnt - dn0, 0);
        chk("rstw_writes", wr_cnt - wr0, 2);
        chk("rstw_m60", mem[8'h60], 8'h01);
        chk("rstw_m61", mem[8'h61], 8'h02);
        chk("rstw_m62", mem[8'h62], 8'hE2);
        chk("rstw_m63", mem[8'h63], 8'hE3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
